// File: rtl/multicycle_control.sv
// Moore controller sequencing a multi-cycle MIPS datapath over one shared memory port,
// with a memory-wait watchdog and a retired-instruction counter.
module multicycle_control #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_out
);

    localparam int WAIT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              memState;
    logic              timeout;
    logic              retire;
    logic              badOp;

    // Next-state, watchdog and retirement decisions for the current state.
    always_comb begin
        memState = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout  = (WAIT_LIMIT > 0) && memState && !mem_ready
                   && (wait_q == WAIT_W'(WAIT_LIMIT));
        state_d  = state_q;
        retire   = 1'b0;
        badOp    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else if (timeout) state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = (funct == FN_JR) ? S_JR : S_REXEC;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    OP_J, OP_JAL:                     state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        badOp   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_REXEC: state_d = S_RWB;
            S_IEXEC: state_d = S_IWB;
            S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP, S_JR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // The counter only runs while stalled in a memory state; any exit or abort restarts it.
        wait_d  = (memState && !mem_ready && !timeout) ? wait_q + WAIT_W'(1) : '0;
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Moore decode of the state register; held at zero throughout reset, FETCH included.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        mem_timeout   = 1'b0;
        if (rst_n) begin
            mem_timeout = timeout;
            case (state_q)
                S_FETCH: begin
                    mem_req   = !timeout;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    illegal   = badOp;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = !timeout;
                    i_or_d  = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = !timeout;
                    mem_we  = !timeout;
                    i_or_d  = 1'b1;
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b001;
                end
                S_RWB: begin
                    reg_dst   = 2'b01;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    branch_ne     = (opcode == OP_BNE);
                    alu_op        = (opcode == OP_BNE) ? 3'b101 : 3'b100;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_ANDI: alu_op = 3'b010;
                        OP_ORI:  alu_op = 3'b011;
                        OP_SLTI: alu_op = 3'b110;
                        default: alu_op = 3'b000;
                    endcase
                end
                S_IWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
                S_JR: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign instr_count = count_q;
    assign state_out   = rst_n ? state_q : 4'd0;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore state-machine controller that sequences a multi-cycle MIPS datapath over a single shared instruction/data memory port with a req/ready handshake.
- Supported instructions: R-type, jr, j, jal, addi, andi, ori, slti, beq, bne, lw, sw.
- Opcode and funct come from the datapath instruction register. They are stable from the DECODE state until the next FETCH completes.
- Includes a memory-wait watchdog and a retired-instruction counter.

Parameters:
WAIT_LIMIT, 16, maximum cycles a memory state waits for mem_ready before abort; 0 disables the watchdog.
CNT_W, 32, width of instr_count.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  write request (valid with mem_req)
i_or_d  output  1  address select: 0 = PC, 1 = ALUOut
ir_write  output  1  load IR from memory read data
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load qualified by ALU zero (datapath applies branch_ne)
branch_ne  output  1  1 = take branch when not zero (bne)
pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  output  3  000 add, 001 R-funct, 010 and, 011 or, 100 beq, 101 bne, 110 slt
reg_dst  output  2  00 rt, 01 rd, 10 $ra
mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC
reg_write  output  1  register file write
illegal  output  1  1-cycle pulse on undefined opcode
mem_timeout  output  1  1-cycle pulse on watchdog abort
instr_count  output  CNT_W  count of retired instructions
state_out  output  4  current state encoding

Behaviour:
- Reset (async, rst_n=0):
  - state = FETCH; wait counter = 0; instr_count = 0.
  - Every output is forced to 0 while rst_n=0, including the combinational FETCH decode.
  - The first fetch request is issued in the first cycle after rst_n rises.
- Outputs: decoded from state only, except the handshake-qualified strobes noted per state. Any output not listed for a state is 0.
- State encodings and actions:
  - FETCH (0): mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
    - ir_write and pc_write assert only in a cycle where mem_ready=1; that cycle moves to DECODE.
    - Otherwise stay in FETCH.
  - DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state:
    - lw/sw -> MEMADR
    - R-type, funct != 001000 -> REXEC
    - R-type, funct = 001000 -> JR
    - beq/bne -> BRANCH
    - addi/andi/ori/slti -> IEXEC
    - 000010 / 000011 -> JUMP
    - any other opcode -> FETCH with illegal=1 for that cycle; instr_count does not increment.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=000. lw -> MEMRD; sw -> MEMWR.
  - MEMRD (3): mem_req=1, i_or_d=1. Moves to MEMWB on mem_ready.
  - MEMWB (4): reg_dst=00, mem_to_reg=01, reg_write=1. -> FETCH.
  - MEMWR (5): mem_req=1, mem_we=1, i_or_d=1. Moves to FETCH on mem_ready.
  - REXEC (6): alu_src_a=1, alu_src_b=00, alu_op=001. -> RWB.
  - RWB (7): reg_dst=01, mem_to_reg=00, reg_write=1. -> FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_source=01.
    - beq: alu_op=100, branch_ne=0. bne: alu_op=101, branch_ne=1.
    - -> FETCH.
  - IEXEC (9): alu_src_a=1, alu_src_b=10. alu_op: addi 000, andi 010, ori 011, slti 110. -> IWB.
  - IWB (10): reg_dst=00, mem_to_reg=00, reg_write=1. -> FETCH.
  - JUMP (11): pc_write=1, pc_source=10.
    - jal additionally: reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4).
    - -> FETCH.
  - JR (12): pc_write=1, pc_source=11. -> FETCH.
  - Encodings 13–15: unreachable; recover to FETCH next cycle with no output activity.
- instr_count: increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, IWB, JUMP or JR. Illegal and timeout paths do not increment it.
- Watchdog:
  - The wait counter clears on entry to each memory state (FETCH, MEMRD, MEMWR) and increments on each cycle there with mem_ready=0.
  - With WAIT_LIMIT>0, when the count reaches WAIT_LIMIT and mem_ready is still 0:
    - mem_timeout=1 and mem_req=0 for that cycle;
    - next state = FETCH.
  - A fetch timeout retries the same PC, since pc_write never fired. A MEMRD/MEMWR timeout abandons the instruction; instr_count does not increment.
  - mem_ready=1 in the same cycle the limit is reached: the completion wins, no timeout.
- mem_ready outside a memory state is ignored.
- rst_n asserted mid-instruction: immediate return to FETCH with all outputs 0; instr_count clears.

Test Plan:
- Reset, then mem_ready=1 permanently, IR = add (opcode 000000, funct 100000): states 0,1,6,7,0; reg_write=1 with reg_dst=01 in state 7; instr_count=1.
- lw with mem_ready delayed 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4,0; mem_req held 4 cycles with i_or_d=1; reg_write with mem_to_reg=01 in state 4.
- bne (000101) then jal (000011): in state 8, alu_op=101, branch_ne=1, pc_write_cond=1; in state 11, pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1; instr_count=2.
- jr (funct 001000) -> state 12 with pc_source=11. Opcode 111111 -> illegal pulses once in DECODE, then FETCH, instr_count unchanged.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH: mem_timeout pulses after 4 wait cycles and state returns to FETCH. A subsequent mem_ready=1 fetches with ir_write and pc_write in the same cycle.
- rst_n pulled low during MEMWR: mem_we and mem_req drop to 0 asynchronously; state_out=0; instr_count=0.
